// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: HD44780-style LCD write strobe sequencer with power-up and execution waits
//
// Ports:
//   clk        system clock (50 MHz)
//   rst_n      asynchronous active-low reset
//   req_valid  write request present
//   req_ready  high only in IDLE; a request is accepted when req_valid && req_ready
//   req_rs     register select of the request: 0 command, 1 data
//   req_data   byte to write
//   lcd_data   LCD data bus, latched on accept and held until the next accept
//   lcd_ctrl   {RW, RS}; RW is always 0
//   lcd_enable LCD E strobe, registered
//   busy       high whenever the sequencer is not IDLE
module lcd_write_sequencer #(
    parameter int POWERON_CYCLES    = 750000,
    parameter int SETUP_CYCLES      = 4,
    parameter int PULSE_CYCLES      = 24,
    parameter int HOLD_CYCLES       = 2,
    parameter int WAIT_CYCLES       = 2500,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic [7:0] lcd_data,
    output logic [1:0] lcd_ctrl,
    output logic       lcd_enable,
    output logic       busy
);
    localparam int M0   = POWERON_CYCLES > SETUP_CYCLES ? POWERON_CYCLES : SETUP_CYCLES;
    localparam int M1   = M0 > PULSE_CYCLES ? M0 : PULSE_CYCLES;
    localparam int M2   = M1 > HOLD_CYCLES ? M1 : HOLD_CYCLES;
    localparam int M3   = M2 > WAIT_CYCLES ? M2 : WAIT_CYCLES;
    localparam int MAXC = M3 > CLEAR_WAIT_CYCLES ? M3 : CLEAR_WAIT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {INIT, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          clear_cmd;

    // Each timed state lasts exactly the loaded count: leave when the counter reads 1.
    assign last      = cnt == CW'(1);
    // Clear display / return home need the long execution wait; decided from the latched byte.
    assign clear_cmd = !lcd_ctrl[0] && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03);
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt        <= CW'(POWERON_CYCLES);
            lcd_data   <= 8'h00;
            lcd_ctrl   <= 2'b00;
            lcd_enable <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (last) state <= IDLE;
                    else cnt <= cnt - CW'(1);
                end
                IDLE: begin
                    if (req_valid) begin
                        state    <= SETUP;
                        cnt      <= CW'(SETUP_CYCLES);
                        lcd_data <= req_data;
                        lcd_ctrl <= {1'b0, req_rs};
                    end
                end
                SETUP: begin
                    if (last) begin
                        state      <= PULSE;
                        cnt        <= CW'(PULSE_CYCLES);
                        lcd_enable <= 1'b1;
                    end else cnt <= cnt - CW'(1);
                end
                PULSE: begin
                    if (last) begin
                        state      <= HOLD;
                        cnt        <= CW'(HOLD_CYCLES);
                        lcd_enable <= 1'b0;
                    end else cnt <= cnt - CW'(1);
                end
                HOLD: begin
                    if (last) begin
                        state <= WAIT;
                        cnt   <= clear_cmd ? CW'(CLEAR_WAIT_CYCLES) : CW'(WAIT_CYCLES);
                    end else cnt <= cnt - CW'(1);
                end
                WAIT: begin
                    if (last) state <= IDLE;
                    else cnt <= cnt - CW'(1);
                end
                default: begin
                    state      <= INIT;
                    cnt        <= CW'(POWERON_CYCLES);
                    lcd_enable <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: randomized self-checking bench for lcd_write_sequencer
module tb_lcd_write_sequencer;
    localparam int PO = 4, SU = 2, PU = 3, HO = 1, WA = 5, CWT = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    lcd_write_sequencer #(
        .POWERON_CYCLES(PO), .SETUP_CYCLES(SU), .PULSE_CYCLES(PU),
        .HOLD_CYCLES(HO), .WAIT_CYCLES(WA), .CLEAR_WAIT_CYCLES(CWT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_data(req_data), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
        .lcd_enable(lcd_enable), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // One write transaction; expected waveform is derived from the phase lengths:
    // k edges after the accept edge, E is high for SU <= k < SU+PU and ready returns at k = SU+PU+HO+wait.
    task automatic xfer(input logic rs, input logic [7:0] d, input bit hold_valid, output int rise);
        int n;
        int wt;
        int total;
        logic exp_en;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        wt    = (!rs && d >= 8'h01 && d <= 8'h03) ? CWT : WA;
        total = SU + PU + HO + wt;
        rise  = -1;
        for (int k = 0; k <= total; k++) begin
            @(posedge clk); #1;
            if (!hold_valid) req_valid = 1'b0;
            req_rs   = 1'($urandom);
            req_data = 8'($urandom);
            if (rise < 0 && lcd_enable === 1'b1) rise = cyc;
            exp_en = (k >= SU && k < SU + PU);
            checks++;
            if (lcd_enable !== exp_en) begin
                errors++;
                $display("FAIL enable k=%0d data=%h got %b want %b", k, d, lcd_enable, exp_en);
            end
            checks++;
            if (req_ready !== (k == total)) begin
                errors++;
                $display("FAIL ready k=%0d data=%h got %b want %b", k, d, req_ready, k == total);
            end
            checks++;
            if (busy !== (k != total)) begin
                errors++;
                $display("FAIL busy k=%0d data=%h got %b want %b", k, d, busy, k != total);
            end
            checks++;
            if (lcd_data !== d || lcd_ctrl !== {1'b0, rs}) begin
                errors++;
                $display("FAIL bus k=%0d got %h/%b want %h/%b", k, lcd_data, lcd_ctrl, d, {1'b0, rs});
            end
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1 || lcd_enable !== 1'b0 || lcd_data !== 8'h00 || lcd_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL reset_state got rdy=%b busy=%b en=%b data=%h ctrl=%b want 0 1 0 00 00",
                     req_ready, busy, lcd_enable, lcd_data, lcd_ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_release got ready=%b want 0", req_ready);
        end
        for (int i = 1; i <= PO + 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (req_ready !== (i >= PO) || busy !== (i < PO)) begin
                errors++;
                $display("FAIL init_wait edge=%0d got rdy=%b busy=%b want %b %b",
                         i, req_ready, busy, i >= PO, i < PO);
            end
        end
    endtask

    task automatic test_data_write();
        int r;
        xfer(1'b1, 8'h41, 1'b0, r);
    endtask

    task automatic test_clear_cmd();
        int r;
        xfer(1'b0, 8'h01, 1'b0, r);
        xfer(1'b0, 8'h38, 1'b0, r);
        xfer(1'b0, 8'h02, 1'b0, r);
        xfer(1'b0, 8'h03, 1'b0, r);
        xfer(1'b1, 8'h01, 1'b0, r);
    endtask

    task automatic test_back_to_back();
        int r1;
        int r2;
        xfer(1'b1, 8'h48, 1'b1, r1);
        xfer(1'b1, 8'h49, 1'b1, r2);
        req_valid = 1'b0;
        checks++;
        if (r2 - r1 !== 12) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 12", r2 - r1);
        end
    endtask

    task automatic test_stability();
        int r;
        xfer(1'b1, 8'h5A, 1'b0, r);
        for (int i = 0; i < 4; i++) begin
            req_data = 8'($urandom);
            req_rs   = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if (lcd_data !== 8'h5A || lcd_ctrl !== 2'b01) begin
                errors++;
                $display("FAIL idle_hold got %h/%b want 5a/01", lcd_data, lcd_ctrl);
            end
        end
    endtask

    task automatic test_reset_in_pulse();
        int n;
        n = 0;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'hA5;
        while (lcd_enable !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (lcd_enable !== 1'b1) begin
            errors++;
            $display("FAIL pulse_timeout got %b want 1", lcd_enable);
        end
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (lcd_enable !== 1'b0 || lcd_data !== 8'h00 || lcd_ctrl !== 2'b00 || req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got en=%b data=%h ctrl=%b rdy=%b busy=%b want 0 00 00 0 1",
                     lcd_enable, lcd_data, lcd_ctrl, req_ready, busy);
        end
        test_reset();
    endtask

    task automatic test_random();
        int r;
        logic rs;
        logic [7:0] d;
        for (int i = 0; i < 25; i++) begin
            rs = 1'($urandom);
            case ($urandom_range(0, 3))
                0: d = 8'($urandom_range(1, 3));
                1: d = 8'h38;
                2: d = 8'h00;
                default: d = 8'($urandom);
            endcase
            xfer(rs, d, 1'($urandom), r);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_clear_cmd();
        test_back_to_back();
        test_stability();
        test_reset_in_pulse();
        test_data_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_write_sequencer.md
LCD_WRITE_SEQUENCER -- requirements
Module: lcd_write_sequencer

Interface
REQ-001 SHALL have parameter POWERON_CYCLES, default 750000, post-reset LCD power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter SETUP_CYCLES, default 4, RS/data setup time before enable rises.
REQ-003 SHALL have parameter PULSE_CYCLES, default 24, lcd_enable high width.
REQ-004 SHALL have parameter HOLD_CYCLES, default 2, data/RS hold time after enable falls.
REQ-005 SHALL have parameter WAIT_CYCLES, default 2500, execution wait for ordinary writes (50 us).
REQ-006 SHALL have parameter CLEAR_WAIT_CYCLES, default 82000, execution wait for clear/home commands (1.64 ms).
REQ-007 SHALL have port clk, input, 1, single clock of the block (the 50 MHz system clock).
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port req_valid, input, 1, write request present.
REQ-010 SHALL have port req_ready, output, 1, block can accept a request.
REQ-011 SHALL have port req_rs, input, 1, register select: 0 command, 1 data.
REQ-012 SHALL have port req_data, input, 8, byte to write.
REQ-013 SHALL have port lcd_data, output, 8, LCD data bus.
REQ-014 SHALL have port lcd_ctrl, output, 2, bit0 = RS, bit1 = RW.
REQ-015 SHALL have port lcd_enable, output, 1, LCD E strobe.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement states INIT, IDLE, SETUP, PULSE, HOLD, WAIT with one down-counter sized for the largest parameter.
REQ-018 SHALL stay in INIT for exactly POWERON_CYCLES cycles after reset release, then enter IDLE.
REQ-019 SHALL drive req_ready = 1 only in IDLE, combinationally from state.
REQ-020 SHALL accept a request on a rising edge with req_valid && req_ready, latching req_rs and req_data and entering SETUP.
REQ-021 SHALL, on the accepting edge, load lcd_data <= req_data and lcd_ctrl <= {1'b0, req_rs}; RW is always 0.
REQ-022 SHALL hold SETUP for exactly SETUP_CYCLES cycles with lcd_enable = 0.
REQ-023 SHALL hold lcd_enable = 1 for exactly PULSE_CYCLES consecutive cycles (state PULSE), registered, glitch-free.
REQ-024 SHALL hold HOLD for exactly HOLD_CYCLES cycles with lcd_enable = 0 and lcd_data/lcd_ctrl unchanged.
REQ-025 SHALL hold WAIT for CLEAR_WAIT_CYCLES when the latched rs = 0 and the latched data is 8'h01 or 8'h02 or 8'h03, otherwise for WAIT_CYCLES, then enter IDLE.
REQ-026 SHALL keep lcd_data and lcd_ctrl at their last values in WAIT and IDLE until the next accept.
REQ-027 SHALL ignore req_valid, req_rs and req_data in every state other than IDLE; the requester holds them until accepted.
REQ-028 SHALL accept back-to-back requests: req_ready is high for the cycle after WAIT ends, so the accept-to-accept spacing is 1 + SETUP + PULSE + HOLD + wait cycles.
REQ-029 SHALL require every cycle parameter to be >= 1; behaviour for 0 is undefined.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously force state INIT, counter = POWERON_CYCLES, lcd_data = 8'h00, lcd_ctrl = 2'b00, lcd_enable = 0.
REQ-031 SHALL, while rst_n = 0, force req_ready = 0 and busy = 1.
REQ-032 SHALL restart from INIT with lcd_enable dropped immediately on reset assertion mid-transfer, including during PULSE; no partial transfer resumes.

Verification
(Parameters for the bench: POWERON=4, SETUP=2, PULSE=3, HOLD=1, WAIT=5, CLEAR_WAIT=9.)
REQ-033 SHALL cover power-up: release rst_n -> req_ready = 0 for 4 cycles, then 1; busy mirrors it.
REQ-034 SHALL cover a data write: req_rs=1, req_data=8'h41 -> lcd_ctrl=2'b01, lcd_data=8'h41 from the accept edge; enable low 2 cycles, high 3 cycles, low; req_ready returns after 1+5 further cycles.
REQ-035 SHALL cover a clear command: req_rs=0, req_data=8'h01 -> identical strobe, then a 9-cycle WAIT; a command of 8'h38 gets a 5-cycle WAIT.
REQ-036 SHALL cover back-to-back writes with req_valid held high: 8'h48 then 8'h49 -> two enable pulses whose rising edges are 12 cycles apart.
REQ-037 SHALL cover reset in PULSE: assert rst_n low during the 2nd enable-high cycle -> lcd_enable = 0 and lcd_data = 8'h00 asynchronously, and the INIT wait repeats after release.
REQ-038 SHALL cover request stability: change req_data while busy -> lcd_data unchanged until the next accept.
